// File: rtl/tlb_op_ctrl_pkg.sv
// cpuDefine: shared TLB-op encodings, invtlb op codes, index width and controller states
package cpuDefine;
  localparam int TLBNUMSIZE = 4;
  typedef enum logic [2:0] {SRCH, RD, WR, FILL, INV} TlbOp;
  localparam logic [4:0] INVTLB_ALL = 5'd0;
  localparam logic [4:0] INVTLB_ALL1 = 5'd1;
  localparam logic [4:0] INVTLB_G = 5'd2;
  localparam logic [4:0] INVTLB_NG = 5'd3;
  localparam logic [4:0] INVTLB_NG_ASID = 5'd4;
  localparam logic [4:0] INVTLB_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INVTLB_GA_VA = 5'd6;
  typedef enum logic [2:0] {IDLE, SRCH_REQ, SRCH_RSP, EXEC, INV_WALK, DONE} state_t;
endpackage

// File: rtl/tlb_op_ctrl_inv_match.sv
// tlb_inv_match: combinational invtlb match of one TLB entry (ent_g/asid/vppn/ps) against inv_op/asid/vppn -> hit
module tlb_inv_match
  import cpuDefine::*;
(
  input  logic        ent_g,
  input  logic [9:0]  ent_asid,
  input  logic [18:0] ent_vppn,
  input  logic [5:0]  ent_ps,
  input  logic [4:0]  inv_op,
  input  logic [9:0]  inv_asid,
  input  logic [18:0] inv_vppn,
  output logic        hit
);
  logic asid_eq, va_eq;
  assign asid_eq = ent_asid == inv_asid;
  // 4KB pages compare the full vppn; huge pages only the bits above the page offset
  assign va_eq = ent_ps == 6'd12 ? ent_vppn == inv_vppn : ent_vppn[18:9] == inv_vppn[18:9];
  always_comb begin
    hit = (inv_op == INVTLB_ALL || inv_op == INVTLB_ALL1) ? 1'b1 :
          inv_op == INVTLB_G          ? ent_g :
          inv_op == INVTLB_NG         ? ~ent_g :
          inv_op == INVTLB_NG_ASID    ? ~ent_g & asid_eq :
          inv_op == INVTLB_NG_ASID_VA ? ~ent_g & asid_eq & va_eq :
          inv_op == INVTLB_GA_VA      ? (ent_g | asid_eq) & va_eq : 1'b0;
  end
endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences committed TLB ops (search/read/write/fill/invtlb) into one-cycle strobes; invtlb walk enabled by TLB_INVTLB_EN
// ports: clk, reset (async high); op_valid/op_ready/op_type/inv_* handshake; csr_* inputs; s_* search port;
//        s1e/s1_ne/s1_index, re/r_index, we/w_index, ent_*/walk_index/clr_e, done, op_err, fetch_again
module tlb_op_ctrl
  import cpuDefine::*;
#(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_type,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  input  logic [18:0]     csr_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [IDXW-1:0] csr_index,
  output logic [18:0]     s_vppn,
  output logic [9:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  output logic            s1e,
  output logic            s1_ne,
  output logic [IDXW-1:0] s1_index,
  output logic            re,
  output logic [IDXW-1:0] r_index,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  input  logic            ent_e,
  input  logic            ent_g,
  input  logic [9:0]      ent_asid,
  input  logic [18:0]     ent_vppn,
  input  logic [5:0]      ent_ps,
  output logic [IDXW-1:0] walk_index,
  output logic            clr_e,
  output logic            done,
  output logic            op_err,
  output logic            fetch_again
);
  state_t state, nxt;
  TlbOp op_q;
  logic err_q, inv_ok, walk_last, accept;
  logic [IDXW-1:0] fill_idx, fill_q;
  assign accept = op_valid & op_ready;
`ifdef TLB_INVTLB_EN
  logic [IDXW-1:0] walk_q;
  logic [4:0] inv_op_q;
  logic [9:0] inv_asid_q;
  logic [18:0] inv_vppn_q;
  logic hit;
  tlb_inv_match u_match (
    .ent_g(ent_g), .ent_asid(ent_asid), .ent_vppn(ent_vppn), .ent_ps(ent_ps),
    .inv_op(inv_op_q), .inv_asid(inv_asid_q), .inv_vppn(inv_vppn_q), .hit(hit)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      walk_q <= '0;
      inv_op_q <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
    end else if (accept) begin
      walk_q <= '0;
      inv_op_q <= inv_op;
      inv_asid_q <= inv_asid;
      inv_vppn_q <= inv_vppn;
    end else if (state == INV_WALK) begin
      walk_q <= walk_q + IDXW'(1);
    end
  end
  assign inv_ok = inv_op <= INVTLB_GA_VA;
  assign walk_last = walk_q == IDXW'(TLBNUM - 1);
  assign walk_index = walk_q;
  assign clr_e = state == INV_WALK && ent_e && hit;
`else
  logic unused_inv;
  assign unused_inv = ^{inv_op, inv_asid, inv_vppn, ent_e, ent_g, ent_asid, ent_vppn, ent_ps};
  assign inv_ok = 1'b0;
  assign walk_last = 1'b1;
  assign walk_index = '0;
  assign clr_e = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q <= SRCH;
      err_q <= 1'b0;
      fill_idx <= '0;
      fill_q <= '0;
    end else begin
      state <= nxt;
      fill_idx <= fill_idx + IDXW'(1);
      if (accept) begin
        op_q <= TlbOp'(op_type);
        err_q <= op_type == INV && !inv_ok;
        fill_q <= fill_idx;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (op_valid) nxt = op_type == SRCH ? SRCH_REQ :
                                    (op_type == RD || op_type == WR || op_type == FILL) ? EXEC :
                                    (op_type == INV && inv_ok) ? INV_WALK : DONE;
      SRCH_REQ: nxt = SRCH_RSP;
      SRCH_RSP: nxt = DONE;
      EXEC:     nxt = DONE;
      INV_WALK: nxt = walk_last ? DONE : INV_WALK;
      default:  nxt = IDLE;
    endcase
  end
  assign op_ready = state == IDLE;
  assign s_vppn = state == SRCH_REQ ? csr_vppn : '0;
  assign s_asid = state == SRCH_REQ ? csr_asid : '0;
  assign s1e = state == SRCH_RSP;
  assign s1_ne = s1e & ~s_found;
  assign s1_index = s1e ? s_index : '0;
  assign re = state == EXEC && op_q == RD;
  assign r_index = re ? csr_index : '0;
  assign we = state == EXEC && (op_q == WR || op_q == FILL);
  assign w_index = !we ? '0 : op_q == FILL ? fill_q : csr_index;
  assign done = state == DONE;
  assign fetch_again = done;
  assign op_err = done & err_q;
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: scoreboard bench for tlb_op_ctrl; walk tests enabled with TLB_INVTLB_EN
module tb_tlb_op_ctrl;
  import cpuDefine::*;
  logic clk = 0, reset = 1;
  logic op_valid = 0, op_ready;
  logic [2:0] op_type = 0;
  logic [4:0] inv_op = 0;
  logic [9:0] inv_asid = 0, csr_asid = 0, s_asid, ent_asid;
  logic [18:0] inv_vppn = 0, csr_vppn = 0, s_vppn, ent_vppn;
  logic [3:0] csr_index = 0, s_index = 0, s1_index, r_index, w_index, walk_index;
  logic s_found = 0, s1e, s1_ne, re, we, ent_e, ent_g, clr_e, done, op_err, fetch_again;
  logic [5:0] ent_ps;
  logic t_e[16], t_g[16];
  logic [9:0] t_asid[16];
  logic [18:0] t_vppn[16];
  logic [5:0] t_ps[16];
  typedef struct {int kind; int idx; logic flag; int cyc;} ev_t;
  ev_t q[$];
  int cyc = 0, total = 0, bad = 0, rel = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ent_e = t_e[walk_index];
  assign ent_g = t_g[walk_index];
  assign ent_asid = t_asid[walk_index];
  assign ent_vppn = t_vppn[walk_index];
  assign ent_ps = t_ps[walk_index];
  tlb_op_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .csr_vppn(csr_vppn),
    .csr_asid(csr_asid), .csr_index(csr_index), .s_vppn(s_vppn), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s1e(s1e), .s1_ne(s1_ne), .s1_index(s1_index),
    .re(re), .r_index(r_index), .we(we), .w_index(w_index), .ent_e(ent_e), .ent_g(ent_g),
    .ent_asid(ent_asid), .ent_vppn(ent_vppn), .ent_ps(ent_ps), .walk_index(walk_index),
    .clr_e(clr_e), .done(done), .op_err(op_err), .fetch_again(fetch_again)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic push(input int kind, input int idx, input logic flag, input int c);
    ev_t e;
    e.kind = kind; e.idx = idx; e.flag = flag; e.cyc = c;
    q.push_back(e);
  endtask
  task automatic issue(input logic [2:0] t, input logic [4:0] iop, input logic [9:0] ia,
                       input logic [18:0] iv, output int acc);
    int w = 0;
    @(negedge clk);
    op_type = t; inv_op = iop; inv_asid = ia; inv_vppn = iv; op_valid = 1;
    while (!op_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) chk("accept_timeout", op_ready, 1);
    acc = cyc;
    @(posedge clk);
  endtask
  task automatic idle();
    @(negedge clk);
    op_valid = 0;
  endtask
  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  // kinds: 1 s1e, 2 re, 3 we, 4 clr_e, 5 done; flag is s1_ne for search, op_err for done
  always @(negedge clk) begin
    int n, k, i;
    logic f;
    ev_t e;
    if (!reset) begin
      n = int'(s1e) + int'(re) + int'(we) + int'(clr_e) + int'(done);
      if (n > 1) chk("overlap", n, 1);
      if ((op_err || fetch_again) && !done) chk("orphan_pulse", {op_err, fetch_again}, 0);
      if (n == 1) begin
        k = s1e ? 1 : re ? 2 : we ? 3 : clr_e ? 4 : 5;
        i = s1e ? int'(s1_index) : re ? int'(r_index) : we ? int'(w_index) : clr_e ? int'(walk_index) : 0;
        f = s1e ? s1_ne : done ? op_err : 1'b0;
        if (done) chk("fetch_again", fetch_again, 1);
        if (q.size() == 0) chk("unexpected_strobe", k, 0);
        else begin
          e = q.pop_front();
          chk("kind", k, e.kind);
          chk("index", i, e.idx);
          chk("flag", f, e.flag);
          chk("cycle", cyc, e.cyc);
        end
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int a1, a2, e1;
    for (int j = 0; j < 16; j++) begin
      t_e[j] = 0; t_g[j] = 0; t_asid[j] = 0; t_vppn[j] = 0; t_ps[j] = 12;
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", {s1e, re, we, clr_e, done, op_err, fetch_again, walk_index}, 0);
    reset = 0;
    rel = cyc;
    @(negedge clk);
    chk("ready_after_reset", op_ready, 1);
    chk("idle_svppn", s_vppn, 0);
    // search hit
    csr_vppn = 19'h12345; csr_asid = 10'h2A; s_found = 1; s_index = 5;
    issue(SRCH, 0, 0, 0, a1);
    push(1, 5, 0, a1 + 2);
    push(5, 0, 0, a1 + 3);
    idle();
    chk("s_vppn", s_vppn, 19'h12345);
    chk("s_asid", s_asid, 10'h2A);
    drain();
    // search miss
    s_found = 0; s_index = 9;
    issue(SRCH, 0, 0, 0, a1);
    push(1, 9, 1, a1 + 2);
    push(5, 0, 0, a1 + 3);
    idle();
    drain();
    // read and write use csr_index
    csr_index = 11;
    issue(RD, 0, 0, 0, a1);
    push(2, 11, 0, a1 + 1);
    push(5, 0, 0, a1 + 2);
    idle();
    drain();
    csr_index = 3;
    issue(WR, 0, 0, 0, a1);
    push(3, 3, 0, a1 + 1);
    push(5, 0, 0, a1 + 2);
    idle();
    drain();
    // two fills 7 cycles apart: indices differ by 7 mod 16
    issue(FILL, 0, 0, 0, a1);
    e1 = (a1 - rel) & 15;
    push(3, e1, 0, a1 + 1);
    push(5, 0, 0, a1 + 2);
    idle();
    drain();
    while (cyc < a1 + 6) @(negedge clk);
    issue(FILL, 0, 0, 0, a2);
    chk("fill_gap", a2 - a1, 7);
    push(3, (e1 + 7) & 15, 0, a2 + 1);
    push(5, 0, 0, a2 + 2);
    idle();
    drain();
    // illegal invtlb op
    issue(INV, 7, 0, 0, a1);
    push(5, 0, 1, a1 + 1);
    idle();
    drain();
`ifdef TLB_INVTLB_EN
    t_e[2] = 1; t_g[2] = 0; t_asid[2] = 3; t_vppn[2] = 19'h00040;
    t_e[4] = 1; t_g[4] = 1; t_asid[4] = 3; t_vppn[4] = 19'h00040;
    t_e[9] = 1; t_g[9] = 0; t_asid[9] = 4; t_vppn[9] = 19'h00040;
    issue(INV, 5, 3, 19'h00040, a1);
    push(4, 2, 0, a1 + 3);
    push(5, 0, 0, a1 + 17);
    idle();
    drain();
    t_e[11] = 1; t_g[11] = 0; t_asid[11] = 3; t_vppn[11] = 19'h0007F; t_ps[11] = 21;
    t_e[12] = 1; t_g[12] = 1; t_asid[12] = 9; t_vppn[12] = 19'h10040;
    t_e[13] = 0; t_g[13] = 1; t_asid[13] = 3; t_vppn[13] = 19'h00040;
    issue(INV, 6, 3, 19'h00040, a1);
    push(4, 2, 0, a1 + 3);
    push(4, 4, 0, a1 + 5);
    push(4, 11, 0, a1 + 12);
    push(5, 0, 0, a1 + 17);
    idle();
    drain();
    issue(INV, 2, 0, 0, a1);
    push(4, 4, 0, a1 + 5);
    push(4, 12, 0, a1 + 13);
    push(5, 0, 0, a1 + 17);
    idle();
    drain();
`else
    issue(INV, 0, 0, 0, a1);
    push(5, 0, 1, a1 + 1);
    idle();
    drain();
`endif
    // back-to-back with op_valid held high
    csr_index = 7;
    issue(RD, 0, 0, 0, a1);
    push(2, 7, 0, a1 + 1);
    push(5, 0, 0, a1 + 2);
    issue(WR, 0, 0, 0, a2);
    push(3, 7, 0, a2 + 1);
    push(5, 0, 0, a2 + 2);
    chk("b2b_gap", a2 - a1, 3);
    idle();
    drain();
    // reset in the middle of an op
`ifdef TLB_INVTLB_EN
    t_e[8] = 1;
    issue(INV, 0, 0, 0, a1);
    push(4, 2, 0, a1 + 3);
    push(4, 4, 0, a1 + 5);
    idle();
    while (cyc < a1 + 7) @(negedge clk);
    chk("walk_at_6", walk_index, 6);
`else
    issue(SRCH, 0, 0, 0, a1);
    idle();
    chk("s_vppn_pre_reset", s_vppn, 19'h12345);
`endif
    #1 reset = 1;
    #1 chk("reset_mid_outs", {s1e, re, we, clr_e, done, op_err, fetch_again, walk_index, s_vppn}, 0);
    chk("reset_mid_pending", q.size(), 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    rel = cyc;
    @(negedge clk);
    chk("ready_after_mid_reset", op_ready, 1);
    repeat (20) @(negedge clk);
    chk("no_resume", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 Parameter: TLBNUM, default 16, number of TLB entries (power of two); IDXW = log2(TLBNUM).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 op_valid/op_ready  in/out  1/1  committed TLB-instruction handshake from WB; transfer when both high.
REQ-005 op_type  in  3  TlbOp: SRCH, RD, WR, FILL, INV.
REQ-006 inv_op  in  5  invtlb op field; inv_asid in 10; inv_vppn in 19.
REQ-007 csr_vppn in 19, csr_asid in 10, csr_index in IDXW  current TLBEHI/ASID/TLBIDX fields.
REQ-008 s_vppn out 19, s_asid out 10, s_found in 1, s_index in IDXW  TLB search port; result is valid one cycle after the request.
REQ-009 s1e out 1, s1_ne out 1, s1_index out IDXW  search writeback to CSR.
REQ-010 re out 1, r_index out IDXW  TLB read strobe to CSR and TLB.
REQ-011 we out 1, w_index out IDXW  TLB write strobe.
REQ-012 ent_e, ent_g in 1; ent_asid in 10; ent_vppn in 19; ent_ps in 6; walk_index out IDXW  combinational view of entry walk_index.
REQ-013 clr_e out 1  clears entry walk_index.
REQ-014 done out 1  one-cycle completion pulse.
REQ-015 op_err out 1  one-cycle pulse for an illegal inv_op (INE).
REQ-016 fetch_again out 1  one-cycle pulse, coincident with done, requesting refetch at pc+4.

Function
REQ-017 FSM states: IDLE, SRCH_REQ, SRCH_RSP, EXEC, INV_WALK, DONE.
REQ-018 op_ready is high only in IDLE.
REQ-019 On accept, latch op_type and inv_* and enter:
  - SRCH → SRCH_REQ
  - RD/WR/FILL → EXEC
  - INV with legal op → INV_WALK at index 0
  - INV with illegal op (>6) → DONE with op_err.
REQ-020 SRCH_REQ: drive s_vppn=csr_vppn and s_asid=csr_asid; next state SRCH_RSP.
REQ-021 SRCH_RSP: pulse s1e with s1_ne=~s_found; s1_index=s_index; next state DONE.
REQ-022 EXEC, RD: pulse re with r_index=csr_index.
REQ-023 EXEC, WR: pulse we with w_index=csr_index.
REQ-024 EXEC, FILL: pulse we with w_index=fill_idx latched at accept; then DONE.
REQ-025 fill_idx is a free-running IDXW-bit counter: +1 every cycle, wraps TLBNUM-1→0.
REQ-026 INV_WALK: for each walk_index 0..TLBNUM-1, pulse clr_e when ent_e and the match for inv_op holds:
  - 0/1: all
  - 2: g=1
  - 3: g=0
  - 4: g=0 and asid eq
  - 5: g=0, asid eq, va eq
  - 6: (g=1 or asid eq), va eq.
REQ-027 va eq compares vppn[18:0] when ent_ps=12, else vppn[18:9].
REQ-028 INV_WALK exits to DONE after index TLBNUM-1 (TLBNUM cycles).
REQ-029 DONE: pulse done and fetch_again; return to IDLE next cycle.
REQ-030 Latency from accept to done: SRCH 3 cycles, RD/WR/FILL 2, INV TLBNUM+1, illegal INV 1.
REQ-031 Strobes (s1e, re, we, clr_e, done, op_err, fetch_again) are mutually exclusive in time and never exceed one cycle per event.
REQ-032 Once accepted, an op runs to completion; op_valid deasserting mid-op is ignored.

Reset
REQ-033 Reset returns the FSM to IDLE from any state, including mid-walk; no partial walk resumes.
REQ-034 Reset clears all strobes to 0, fill_idx to 0, and all latched fields to 0; op_ready=1 in the first cycle after reset release.

Configuration
REQ-035 Macro TLB_INVTLB_EN defined: INV behaves per REQ-026 to REQ-028.
REQ-036 TLB_INVTLB_EN undefined: INV with any op goes straight to DONE with op_err pulsed; no walk logic is synthesized; clr_e is tied 0.

Structure
REQ-037 Package cpuDefine holds:
  - TlbOp enum
  - invtlb op code constants
  - TLBNUMSIZE (=IDXW)
  - the state enum.
REQ-038 One sub-module, tlb_inv_match: combinational ent_* versus inv_* match per REQ-026/027, instantiated only under TLB_INVTLB_EN.

Verification
REQ-039 SRCH with csr_vppn=0x12345, TLB s_found=1, s_index=5 → s1e at accept+2 with s1_ne=0, s1_index=5; done at +3.
REQ-040 FILL issued twice, 7 cycles apart, TLBNUM=16 → w_index values differ by 7 mod 16; we lasts one cycle each.
REQ-041 INV op=5, asid=3, va=0x00040: entries 2 (g=0, asid 3, va match), 4 (g=1), 9 (asid 4) → clr_e only at walk_index 2; done at accept+17.
REQ-042 INV op=7 → op_err and done same cycle, no clr_e; with TLB_INVTLB_EN undefined, op=0 → same response.
REQ-043 Reset asserted at walk_index 6 → all outputs 0 immediately, op_ready=1 after release, no further clr_e.
REQ-044 Back-to-back op_valid held high → next accept one cycle after done; strobes never overlap.
